// File: rtl/axis_3_to_1_rr_arbiter_if.sv
// AXI-Stream channel bundle used by the 3:1 round-robin arbiter.
// master drives the beat fields and valid; slave drives ready.
interface axis_3_to_1_rr_arbiter_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_3_to_1_rr_arbiter.sv
// Packet-granular round-robin arbiter merging three AXI-Stream inputs onto
// one output. A grant is taken in an IDLE cycle and held until the granted
// input's tlast beat is accepted, so packets never interleave.
// Optional macro AXIS_ARB_PKT_COUNT_EN adds saturating per-input packet
// counters pkt_count_0..2.
module axis_3_to_1_rr_arbiter #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  axis_3_to_1_rr_arbiter_if.slave         axis_input_0,
  axis_3_to_1_rr_arbiter_if.slave         axis_input_1,
  axis_3_to_1_rr_arbiter_if.slave         axis_input_2,
  axis_3_to_1_rr_arbiter_if.master        axis_output
`ifdef AXIS_ARB_PKT_COUNT_EN
  ,
  output logic [31:0]                     pkt_count_0,
  output logic [31:0]                     pkt_count_1,
  output logic [31:0]                     pkt_count_2
`endif
);
  localparam int TKEEP_WIDTH = TDATA_WIDTH / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [1:0]             last_grant_q, last_grant_d;
  logic [2:0]             in_tvalid;
  logic [2:0]             in_tready;
  logic [TDATA_WIDTH-1:0] out_tdata;
  logic [TKEEP_WIDTH-1:0] out_tkeep;
  logic [TUSER_WIDTH-1:0] out_tuser;
  logic                   out_tvalid;
  logic                   out_tlast;
  logic                   pkt_done;

  // Search upward from the input after the last one served, wrapping at 3.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idx = 2'((int'(last) + i) % 3);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign in_tvalid = {axis_input_2.tvalid, axis_input_1.tvalid, axis_input_0.tvalid};

  assign axis_input_0.tready = in_tready[0];
  assign axis_input_1.tready = in_tready[1];
  assign axis_input_2.tready = in_tready[2];

  assign axis_output.tdata  = out_tdata;
  assign axis_output.tkeep  = out_tkeep;
  assign axis_output.tuser  = out_tuser;
  assign axis_output.tvalid = out_tvalid;
  assign axis_output.tlast  = out_tlast;

  assign pkt_done = (state_q == BUSY) && out_tvalid && axis_output.tready && out_tlast;

  // State, grant and round-robin pointer registers.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q      <= IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration in IDLE; in BUSY mux the granted input through and release on tlast.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_tready    = 3'b000;
    out_tvalid   = 1'b0;
    out_tdata    = '0;
    out_tkeep    = '0;
    out_tuser    = '0;
    out_tlast    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_tvalid) begin
          grant_d = rr_pick(last_grant_q, in_tvalid);
          state_d = BUSY;
        end
      end
      BUSY: begin
        case (grant_q)
          2'd0: begin
            out_tvalid   = axis_input_0.tvalid;
            out_tdata    = axis_input_0.tdata;
            out_tkeep    = axis_input_0.tkeep;
            out_tuser    = axis_input_0.tuser;
            out_tlast    = axis_input_0.tlast;
            in_tready[0] = axis_output.tready;
          end
          2'd1: begin
            out_tvalid   = axis_input_1.tvalid;
            out_tdata    = axis_input_1.tdata;
            out_tkeep    = axis_input_1.tkeep;
            out_tuser    = axis_input_1.tuser;
            out_tlast    = axis_input_1.tlast;
            in_tready[1] = axis_output.tready;
          end
          2'd2: begin
            out_tvalid   = axis_input_2.tvalid;
            out_tdata    = axis_input_2.tdata;
            out_tkeep    = axis_input_2.tkeep;
            out_tuser    = axis_input_2.tuser;
            out_tlast    = axis_input_2.tlast;
            in_tready[2] = axis_output.tready;
          end
          default: ;
        endcase
        if (out_tvalid && axis_output.tready && out_tlast) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXIS_ARB_PKT_COUNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Count accepted tlast beats per input, saturating at all-ones.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      pkt_count_0 <= 32'd0;
      pkt_count_1 <= 32'd0;
      pkt_count_2 <= 32'd0;
    end else if (pkt_done) begin
      case (grant_q)
        2'd0:    pkt_count_0 <= sat_inc(pkt_count_0);
        2'd1:    pkt_count_1 <= sat_inc(pkt_count_1);
        2'd2:    pkt_count_2 <= sat_inc(pkt_count_2);
        default: ;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_axis_3_to_1_rr_arbiter.sv
// Scoreboard bench for the 3:1 round-robin AXI-Stream arbiter.
`timescale 1ns/1ps
module tb_axis_3_to_1_rr_arbiter;
  localparam int TDW = 256;
  localparam int TUW = 128;
  localparam int TKW = TDW / 8;

  typedef struct packed {
    logic [TDW-1:0] tdata;
    logic [TKW-1:0] tkeep;
    logic [TUW-1:0] tuser;
    logic           tlast;
  } beat_t;

  logic axis_aclk   = 1'b0;
  logic axis_resetn = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  axis_3_to_1_rr_arbiter_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) in0 ();
  axis_3_to_1_rr_arbiter_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) in1 ();
  axis_3_to_1_rr_arbiter_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) in2 ();
  axis_3_to_1_rr_arbiter_if #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) out_if ();

`ifdef AXIS_ARB_PKT_COUNT_EN
  logic [31:0] pkt_count_0, pkt_count_1, pkt_count_2;
`endif

  axis_3_to_1_rr_arbiter #(.TDATA_WIDTH(TDW), .TUSER_WIDTH(TUW)) dut (
    .axis_aclk    (axis_aclk),
    .axis_resetn  (axis_resetn),
    .axis_input_0 (in0),
    .axis_input_1 (in1),
    .axis_input_2 (in2),
    .axis_output  (out_if)
`ifdef AXIS_ARB_PKT_COUNT_EN
    ,
    .pkt_count_0  (pkt_count_0),
    .pkt_count_1  (pkt_count_1),
    .pkt_count_2  (pkt_count_2)
`endif
  );

  beat_t       src_q0[$], src_q1[$], src_q2[$];
  beat_t       sb_q[$];
  int          beat_cyc[$];
  int          cyc        = 0;
  int          beats_seen = 0;
  bit          rdy_toggle = 1'b0;
  bit          t3_active  = 1'b0;
  bit          f0, f1, f2;
  int          n_chk      = 0;
  int          n_err      = 0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(input int id, input int pkt, input int b, input bit last);
    beat_t bt;
    for (int w = 0; w < TDW / 32; w++) bt.tdata[w*32 +: 32] = $urandom;
    bt.tdata[31:0] = {8'(id), 8'(pkt), 16'(b)};
    for (int w = 0; w < TUW / 32; w++) bt.tuser[w*32 +: 32] = $urandom;
    bt.tkeep = last ? ($urandom | 32'h1) : '1;
    bt.tlast = last;
    return bt;
  endfunction

  // Queue one packet on a source and its expected beats on the scoreboard.
  task automatic push_pkt(input int id, input int pkt, input int n);
    beat_t bt;
    for (int b = 0; b < n; b++) begin
      bt = mk_beat(id, pkt, b, b == n - 1);
      case (id)
        0:       src_q0.push_back(bt);
        1:       src_q1.push_back(bt);
        default: src_q2.push_back(bt);
      endcase
      sb_q.push_back(bt);
    end
  endtask

  task automatic present_all();
    if (src_q0.size() > 0) begin
      in0.tvalid = 1'b1; in0.tdata = src_q0[0].tdata; in0.tkeep = src_q0[0].tkeep;
      in0.tuser = src_q0[0].tuser; in0.tlast = src_q0[0].tlast;
    end else begin
      in0.tvalid = 1'b0; in0.tdata = '0; in0.tkeep = '0; in0.tuser = '0; in0.tlast = 1'b0;
    end
    if (src_q1.size() > 0) begin
      in1.tvalid = 1'b1; in1.tdata = src_q1[0].tdata; in1.tkeep = src_q1[0].tkeep;
      in1.tuser = src_q1[0].tuser; in1.tlast = src_q1[0].tlast;
    end else begin
      in1.tvalid = 1'b0; in1.tdata = '0; in1.tkeep = '0; in1.tuser = '0; in1.tlast = 1'b0;
    end
    if (src_q2.size() > 0) begin
      in2.tvalid = 1'b1; in2.tdata = src_q2[0].tdata; in2.tkeep = src_q2[0].tkeep;
      in2.tuser = src_q2[0].tuser; in2.tlast = src_q2[0].tlast;
    end else begin
      in2.tvalid = 1'b0; in2.tdata = '0; in2.tkeep = '0; in2.tuser = '0; in2.tlast = 1'b0;
    end
  endtask

  // Source drivers and downstream ready: handshakes sampled at negedge, updates after posedge.
  initial begin
    present_all();
    out_if.tready = 1'b1;
    forever begin
      @(negedge axis_aclk);
      f0 = in0.tvalid && in0.tready;
      f1 = in1.tvalid && in1.tready;
      f2 = in2.tvalid && in2.tready;
      @(posedge axis_aclk);
      #1;
      cyc++;
      if (f0 && src_q0.size() > 0) void'(src_q0.pop_front());
      if (f1 && src_q1.size() > 0) void'(src_q1.pop_front());
      if (f2 && src_q2.size() > 0) void'(src_q2.pop_front());
      present_all();
      out_if.tready = rdy_toggle ? ~out_if.tready : 1'b1;
    end
  end

  // Output monitor: pop the scoreboard on every accepted beat.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge axis_aclk);
      if (out_if.tvalid && out_if.tready) begin
        beats_seen++;
        beat_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          check_eq("unexpected_beat", 256'(out_if.tvalid), 256'(0));
        end else begin
          exp_b = sb_q.pop_front();
          check_eq("tdata", out_if.tdata, exp_b.tdata);
          check_eq("tkeep", 256'(out_if.tkeep), 256'(exp_b.tkeep));
          check_eq("tuser", 256'(out_if.tuser), 256'(exp_b.tuser));
          check_eq("tlast", 256'(out_if.tlast), 256'(exp_b.tlast));
        end
      end else if (out_if.tvalid && sb_q.size() > 0) begin
        check_eq("hold_data", out_if.tdata, sb_q[0].tdata);
      end
      if (t3_active && out_if.tvalid) begin
        check_eq("in2_ready_mirror", 256'(in2.tready), 256'(out_if.tready));
        check_eq("in0_ready_off", 256'(in0.tready), 256'(0));
        check_eq("in1_ready_off", 256'(in1.tready), 256'(0));
      end
    end
  end

  task automatic wait_drain(input string tag);
    int  n;
    bit  pending;
    n = 0;
    while ((sb_q.size() != 0 || src_q0.size() != 0 || src_q1.size() != 0 ||
            src_q2.size() != 0) && n < 400) begin
      @(negedge axis_aclk);
      n++;
    end
    pending = (sb_q.size() != 0);
    check_eq({tag, "_drain_timeout"}, 256'(pending), 256'(0));
    repeat (3) @(negedge axis_aclk);
  endtask

  task automatic wait_beats(input int target);
    int n;
    bit late;
    n = 0;
    while (beats_seen < target && n < 200) begin
      @(negedge axis_aclk);
      n++;
    end
    late = (beats_seen < target);
    check_eq("beat_wait_timeout", 256'(late), 256'(0));
  endtask

  task automatic check_offsets(input string tag, input int exp_off[$]);
    check_eq({tag, "_beat_count"}, 256'(beat_cyc.size()), 256'(exp_off.size()));
    for (int k = 0; k < beat_cyc.size() && k < exp_off.size(); k++)
      check_eq({tag, "_beat_cycle"}, 256'(beat_cyc[k] - beat_cyc[0]), 256'(exp_off[k]));
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_in0_ready"}, 256'(in0.tready), 256'(0));
    check_eq({tag, "_in1_ready"}, 256'(in1.tready), 256'(0));
    check_eq({tag, "_in2_ready"}, 256'(in2.tready), 256'(0));
    check_eq({tag, "_out_valid"}, 256'(out_if.tvalid), 256'(0));
  endtask

  initial begin
    int t1_off[$];
    int base;
    for (int k = 0; k < 12; k++) t1_off.push_back((k / 4) * 5 + (k % 4));

    // reset state
    repeat (3) @(posedge axis_aclk);
    @(negedge axis_aclk);
    check_quiet("reset");
    check_eq("reset_out_tlast", 256'(out_if.tlast), 256'(0));
    check_eq("reset_out_tdata", out_if.tdata, 256'(0));
    check_eq("reset_out_tuser", 256'(out_if.tuser), 256'(0));
    @(posedge axis_aclk); #3 axis_resetn = 1'b1;
    repeat (2) @(negedge axis_aclk);

    // three simultaneous 4-beat packets: order 0,1,2 with one bubble between
    beat_cyc.delete();
    push_pkt(0, 0, 4); push_pkt(1, 0, 4); push_pkt(2, 0, 4);
    wait_drain("t1");
    check_offsets("t1", t1_off);

    // input 0 requests during packet A on input 1; no interleave
    beat_cyc.delete();
    base = beats_seen;
    push_pkt(1, 1, 3);
    wait_beats(base + 1);
    push_pkt(0, 1, 2);
    wait_drain("t2");
    check_offsets("t2", '{0, 1, 2, 4, 5});

    // toggling downstream ready during a 5-beat packet on input 2
    beat_cyc.delete();
    rdy_toggle = 1'b1;
    t3_active  = 1'b1;
    push_pkt(2, 2, 5);
    wait_drain("t3");
    t3_active  = 1'b0;
    rdy_toggle = 1'b0;
    check_eq("t3_beat_count", 256'(beat_cyc.size()), 256'(5));
    repeat (2) @(negedge axis_aclk);

    // input 0 alone, three single-beat packets
    beat_cyc.delete();
    push_pkt(0, 3, 1); push_pkt(0, 4, 1); push_pkt(0, 5, 1);
    wait_drain("t4");
    check_offsets("t4", '{0, 2, 4});

    // asynchronous reset mid-packet on input 1
    base = beats_seen;
    push_pkt(1, 6, 4);
    wait_beats(base + 2);
    @(posedge axis_aclk); #3 axis_resetn = 1'b0;
    src_q1.delete();
    sb_q.delete();
    @(negedge axis_aclk);
    check_quiet("in_reset");
    beat_cyc.delete();
    push_pkt(0, 7, 2); push_pkt(1, 7, 2);
    @(negedge axis_aclk);
    check_quiet("in_reset_req");
    @(posedge axis_aclk); #3 axis_resetn = 1'b1;
    wait_drain("t5");
    check_offsets("t5", '{0, 1, 3, 4});

    // packet counts: 2, 3 and 1 packets on inputs 0, 1 and 2
    @(posedge axis_aclk); #3 axis_resetn = 1'b0;
    @(posedge axis_aclk); #3 axis_resetn = 1'b1;
    push_pkt(0, 8, 2); push_pkt(0, 9, 1);
    wait_drain("t6a");
    push_pkt(1, 8, 1); push_pkt(1, 9, 3); push_pkt(1, 10, 2);
    wait_drain("t6b");
    push_pkt(2, 8, 4);
    wait_drain("t6c");
`ifdef AXIS_ARB_PKT_COUNT_EN
    check_eq("pkt_count_0", 256'(pkt_count_0), 256'(2));
    check_eq("pkt_count_1", 256'(pkt_count_1), 256'(3));
    check_eq("pkt_count_2", 256'(pkt_count_2), 256'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
